// File: rtl/ram_responder_pkg.sv
// rtl/ram_responder_pkg.sv - shared state encoding and address slicing constants for the RAM responder
package ram_responder_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_WAIT = 2'd2,
        RELEASE = 2'd3
    } rspState_t;

    // Byte address bits below this are dropped to form the word index
    localparam int ADDR_LSB = 2;

endpackage

// File: rtl/ram_array.sv
// rtl/ram_array.sv - word RAM with a core write port, async read, and a host load port
module ram_array
    import ram_responder_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 32,
    parameter int MEM_WORDS = 64,
    localparam int IDX_W    = ADDR_W - ADDR_LSB
) (
    input  logic              clk,
    input  logic              coreWrEn,
    input  logic [IDX_W-1:0]  coreIdx,
    input  logic [DATA_W-1:0] coreWrData,
    output logic [DATA_W-1:0] coreRdData,
    input  logic              loadEn,
    input  logic [IDX_W-1:0]  loadIdx,
    input  logic [DATA_W-1:0] loadData
);

    logic [DATA_W-1:0] mem [MEM_WORDS];

    // Load is written last so it overrides a core write to the same word
    always_ff @(posedge clk) begin
        if (coreWrEn) begin
            mem[coreIdx] <= coreWrData;
        end
        if (loadEn) begin
            mem[loadIdx] <= loadData;
        end
    end

    assign coreRdData = mem[coreIdx];

endmodule

// File: rtl/ram_responder.sv
// rtl/ram_responder.sv - memory-side responder for the CPU readReq/writeReq handshake
module ram_responder
    import ram_responder_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 32,
    parameter int MEM_WORDS = 64,
    parameter int READ_LAT  = 1,
    parameter int WRITE_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] ramAddress,
    input  logic [DATA_W-1:0] ramOut,
    input  logic              readReq,
    input  logic              writeReq,
    output logic [DATA_W-1:0] ramIn,
    output logic              readAck,
    output logic              writeAck,
    input  logic              loadEn,
    input  logic [ADDR_W-1:0] loadAddr,
    input  logic [DATA_W-1:0] loadData,
    output logic              busy,
    output logic              protoErr
);

    localparam int IDX_W = ADDR_W - ADDR_LSB;
    localparam int CNT_W = 8;

    rspState_t         state, stateNext;
    logic [CNT_W-1:0]  cnt, cntNext;
    logic [IDX_W-1:0]  idx, idxNext;
    logic [DATA_W-1:0] wrData, wrDataNext;
    logic [DATA_W-1:0] ramInNext, memRdData;
    logic              readAckNext, writeAckNext, protoErrNext;
    logic              wrPend, wrPendNext;
    logic              memWrEn;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            idx      <= '0;
            wrData   <= '0;
            ramIn    <= '0;
            readAck  <= 1'b0;
            writeAck <= 1'b0;
            protoErr <= 1'b0;
            wrPend   <= 1'b0;
        end else begin
            state    <= stateNext;
            cnt      <= cntNext;
            idx      <= idxNext;
            wrData   <= wrDataNext;
            ramIn    <= ramInNext;
            readAck  <= readAckNext;
            writeAck <= writeAckNext;
            protoErr <= protoErrNext;
            wrPend   <= wrPendNext;
        end
    end

    always_comb begin
        stateNext    = state;
        cntNext      = cnt;
        idxNext      = idx;
        wrDataNext   = wrData;
        ramInNext    = ramIn;
        readAckNext  = 1'b0;
        writeAckNext = 1'b0;
        protoErrNext = protoErr;
        wrPendNext   = wrPend;
        memWrEn      = 1'b0;
        case (state)
            IDLE: begin
                if (readReq) begin
                    idxNext   = ramAddress[ADDR_W-1:ADDR_LSB];
                    cntNext   = CNT_W'(READ_LAT - 1);
                    stateNext = RD_WAIT;
                    if (writeReq) begin
                        protoErrNext = 1'b1;
                        wrPendNext   = 1'b1;
                    end
                end else if (writeReq) begin
                    idxNext    = ramAddress[ADDR_W-1:ADDR_LSB];
                    wrDataNext = ramOut;
                    cntNext    = CNT_W'(WRITE_LAT - 1);
                    stateNext  = WR_WAIT;
                end
            end
            RD_WAIT: begin
                if (cnt != '0) begin
                    cntNext = cnt - 1'b1;
                end else begin
                    ramInNext   = memRdData;
                    readAckNext = 1'b1;
                    stateNext   = RELEASE;
                end
            end
            WR_WAIT: begin
                if (cnt != '0) begin
                    cntNext = cnt - 1'b1;
                end else begin
                    memWrEn      = 1'b1;
                    writeAckNext = 1'b1;
                    stateNext    = RELEASE;
                end
            end
            RELEASE: begin
                // A write left pending by a collision was never acked, so its
                // still-high writeReq must not block the return to IDLE
                if (!readReq && (wrPend || !writeReq)) begin
                    wrPendNext = 1'b0;
                    stateNext  = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    ram_array #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .MEM_WORDS (MEM_WORDS)
    ) u_ram_array (
        .clk        (clk),
        .coreWrEn   (memWrEn),
        .coreIdx    (idx),
        .coreWrData (wrData),
        .coreRdData (memRdData),
        .loadEn     (loadEn),
        .loadIdx    (loadAddr[ADDR_W-1:ADDR_LSB]),
        .loadData   (loadData)
    );

endmodule

// File: tb/tb_ram_responder.sv
// tb/tb_ram_responder.sv - randomized self-checking bench for ram_responder at two latency settings
module tb_ram_responder;

    logic        clk = 1'b0;
    logic        reset      [2];
    logic [7:0]  ramAddress [2];
    logic [31:0] ramOut     [2];
    logic        readReq    [2];
    logic        writeReq   [2];
    logic [31:0] ramIn      [2];
    logic        readAck    [2];
    logic        writeAck   [2];
    logic        loadEn     [2];
    logic [7:0]  loadAddr   [2];
    logic [31:0] loadData   [2];
    logic        busy       [2];
    logic        protoErr   [2];

    int checks = 0;
    int errors = 0;
    int rdAcks [2] = '{0, 0};
    int wrAcks [2] = '{0, 0};

    logic [31:0] refMem   [2][64];
    logic [31:0] refRamIn [2];

    ram_responder #(.READ_LAT(1), .WRITE_LAT(1)) dutA (
        .clk(clk), .reset(reset[0]), .ramAddress(ramAddress[0]), .ramOut(ramOut[0]),
        .readReq(readReq[0]), .writeReq(writeReq[0]), .ramIn(ramIn[0]),
        .readAck(readAck[0]), .writeAck(writeAck[0]), .loadEn(loadEn[0]),
        .loadAddr(loadAddr[0]), .loadData(loadData[0]), .busy(busy[0]), .protoErr(protoErr[0])
    );

    ram_responder #(.READ_LAT(3), .WRITE_LAT(2)) dutB (
        .clk(clk), .reset(reset[1]), .ramAddress(ramAddress[1]), .ramOut(ramOut[1]),
        .readReq(readReq[1]), .writeReq(writeReq[1]), .ramIn(ramIn[1]),
        .readAck(readAck[1]), .writeAck(writeAck[1]), .loadEn(loadEn[1]),
        .loadAddr(loadAddr[1]), .loadData(loadData[1]), .busy(busy[1]), .protoErr(protoErr[1])
    );

    initial forever #5 clk = ~clk;

    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (readAck[u] === 1'b1) rdAcks[u]++;
            if (writeAck[u] === 1'b1) wrAcks[u]++;
        end
    end

    function automatic int rdLat(input int u);
        return (u == 0) ? 1 : 3;
    endfunction

    function automatic int wrLat(input int u);
        return (u == 0) ? 1 : 2;
    endfunction

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Called one time unit after a negedge; returns in the same phase with the request dropped
    task automatic doRead(input int u, input logic [7:0] addr);
        int n;
        int a0;
        a0 = rdAcks[u];
        ramAddress[u] = addr;
        readReq[u] = 1'b1;
        n = 0;
        while (n < 20) begin
            tick();
            n++;
            if (readAck[u] === 1'b1) break;
        end
        refRamIn[u] = refMem[u][addr[7:2]];
        checkEq("rd_latency", 32'(n), 32'(rdLat(u) + 1));
        checkEq("rd_data", ramIn[u], refRamIn[u]);
        readReq[u] = 1'b0;
        ramAddress[u] = 8'($urandom);
        tick();
        checkEq("rd_ack_one_cycle", 32'(readAck[u]), 32'd0);
        checkEq("rd_back_idle", 32'(busy[u]), 32'd0);
        checkEq("rd_data_held", ramIn[u], refRamIn[u]);
        checkEq("rd_ack_count", 32'(rdAcks[u] - a0), 32'd1);
    endtask

    task automatic doWrite(input int u, input logic [7:0] addr, input logic [31:0] data,
                           input bit doLoad, input logic [7:0] lAddr, input logic [31:0] lData);
        int n;
        int a0;
        a0 = wrAcks[u];
        ramAddress[u] = addr;
        ramOut[u] = data;
        writeReq[u] = 1'b1;
        n = 0;
        while (n < 20) begin
            tick();
            n++;
            loadEn[u] = 1'b0;
            if (writeAck[u] === 1'b1) break;
            if (doLoad && n == wrLat(u)) begin
                loadEn[u] = 1'b1;
                loadAddr[u] = lAddr;
                loadData[u] = lData;
            end
        end
        refMem[u][addr[7:2]] = data;
        if (doLoad) refMem[u][lAddr[7:2]] = lData;
        checkEq("wr_latency", 32'(n), 32'(wrLat(u) + 1));
        writeReq[u] = 1'b0;
        ramOut[u] = $urandom;
        tick();
        checkEq("wr_ack_one_cycle", 32'(writeAck[u]), 32'd0);
        checkEq("wr_back_idle", 32'(busy[u]), 32'd0);
        checkEq("wr_ramin_unchanged", ramIn[u], refRamIn[u]);
        checkEq("wr_ack_count", 32'(wrAcks[u] - a0), 32'd1);
    endtask

    initial begin
        int n;
        int a0;
        logic [31:0] d;
        logic [7:0]  a;
        for (int u = 0; u < 2; u++) begin
            reset[u] = 1'b1;
            ramAddress[u] = '0;
            ramOut[u] = '0;
            readReq[u] = 1'b0;
            writeReq[u] = 1'b0;
            loadEn[u] = 1'b0;
            loadAddr[u] = '0;
            loadData[u] = '0;
            refRamIn[u] = '0;
        end
        tick();
        tick();
        for (int u = 0; u < 2; u++) begin
            checkEq("rst_ramIn", ramIn[u], 32'd0);
            checkEq("rst_readAck", 32'(readAck[u]), 32'd0);
            checkEq("rst_writeAck", 32'(writeAck[u]), 32'd0);
            checkEq("rst_busy", 32'(busy[u]), 32'd0);
            checkEq("rst_protoErr", 32'(protoErr[u]), 32'd0);
        end

        // Preload every word while reset is held, then the two known words
        for (int w = 0; w < 66; w++) begin
            for (int u = 0; u < 2; u++) begin
                loadEn[u] = 1'b1;
                loadAddr[u] = (w < 64) ? 8'(w * 4 + $urandom_range(0, 3)) : 8'((w - 64) * 4);
                loadData[u] = (w == 64) ? 32'h04030201 : (w == 65) ? 32'hDEADBEEF : $urandom;
                refMem[u][loadAddr[u][7:2]] = loadData[u];
            end
            tick();
        end
        loadEn[0] = 1'b0;
        loadEn[1] = 1'b0;
        reset[0] = 1'b0;
        reset[1] = 1'b0;
        tick();

        doRead(0, 8'h04);
        doWrite(0, 8'h10, 32'h12345678, 1'b0, 8'h00, 32'h0);
        doRead(0, 8'h13);

        a0 = rdAcks[0];
        doRead(0, 8'h00);
        doRead(0, 8'h04);
        tick();
        tick();
        checkEq("fetch_two_acks", 32'(rdAcks[0] - a0), 32'd2);
        checkEq("fetch_last_data", ramIn[0], 32'hDEADBEEF);

        // Simultaneous requests: read first, pending write follows
        checkEq("no_proto_err_yet", 32'(protoErr[0]), 32'd0);
        d = $urandom;
        ramAddress[0] = 8'h20;
        ramOut[0] = d;
        readReq[0] = 1'b1;
        writeReq[0] = 1'b1;
        n = 0;
        while (n < 20 && readAck[0] !== 1'b1) begin tick(); n++; end
        refRamIn[0] = refMem[0][8];
        checkEq("coll_rd_latency", 32'(n), 32'd2);
        checkEq("coll_rd_data", ramIn[0], refRamIn[0]);
        checkEq("coll_no_wr_ack", 32'(writeAck[0]), 32'd0);
        checkEq("coll_protoErr", 32'(protoErr[0]), 32'd1);
        readReq[0] = 1'b0;
        n = 0;
        while (n < 20 && writeAck[0] !== 1'b1) begin tick(); n++; end
        checkEq("coll_wr_ack", 32'(writeAck[0]), 32'd1);
        refMem[0][8] = d;
        writeReq[0] = 1'b0;
        tick();
        checkEq("protoErr_sticky", 32'(protoErr[0]), 32'd1);
        doRead(0, 8'h22);

        doWrite(0, 8'h30, $urandom, 1'b1, 8'h31, $urandom);
        doRead(0, 8'h30);
        doWrite(0, 8'h34, $urandom, 1'b1, 8'h38, $urandom);
        doRead(0, 8'h34);
        doRead(0, 8'h38);

        doRead(1, 8'h04);
        doWrite(1, 8'h40, $urandom, 1'b0, 8'h00, 32'h0);
        doRead(1, 8'h40);
        doWrite(1, 8'h48, $urandom, 1'b1, 8'h4B, $urandom);
        doRead(1, 8'h48);

        // Request held without dropping: one ack, responder parks in RELEASE
        a0 = rdAcks[1];
        ramAddress[1] = 8'h00;
        readReq[1] = 1'b1;
        repeat (10) tick();
        refRamIn[1] = refMem[1][0];
        checkEq("held_single_ack", 32'(rdAcks[1] - a0), 32'd1);
        checkEq("held_busy", 32'(busy[1]), 32'd1);
        checkEq("held_data", ramIn[1], refRamIn[1]);
        readReq[1] = 1'b0;
        tick();
        checkEq("held_release_idle", 32'(busy[1]), 32'd0);

        // Reset while a write is waiting: nothing commits
        a0 = wrAcks[1];
        ramAddress[1] = 8'h44;
        ramOut[1] = ~refMem[1][17];
        writeReq[1] = 1'b1;
        tick();
        checkEq("wr_wait_busy", 32'(busy[1]), 32'd1);
        reset[1] = 1'b1;
        #1;
        checkEq("midrst_busy", 32'(busy[1]), 32'd0);
        checkEq("midrst_ramIn", ramIn[1], 32'd0);
        refRamIn[1] = '0;
        writeReq[1] = 1'b0;
        tick();
        tick();
        reset[1] = 1'b0;
        tick();
        checkEq("midrst_no_ack", 32'(wrAcks[1] - a0), 32'd0);
        doRead(1, 8'h44);

        for (int i = 0; i < 40; i++) begin
            int u;
            u = $urandom_range(0, 1);
            a = 8'($urandom);
            if ($urandom_range(0, 1) == 0) begin
                doRead(u, a);
            end else begin
                doWrite(u, a, $urandom, $urandom_range(0, 3) == 0,
                        ($urandom_range(0, 1) == 0) ? {a[7:2], 2'($urandom)} : 8'($urandom),
                        $urandom);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
